// File: rtl/fpu_issue_ctrl_if.sv
// Request/response handshake bundle for fpu_issue_ctrl.
// master drives requests and consumes responses; slave is the controller.
interface fpu_issue_ctrl_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [1:0]       req_rmode;
  logic [31:0]      req_opa;
  logic [31:0]      req_opb;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic [8:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, req_op, req_rmode,
    output req_opa, req_opb, req_tag,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_flags,
    input  rsp_tag,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_op, req_rmode,
    input  req_opa, req_opb, req_tag,
    output req_ready,
    output rsp_valid, rsp_data, rsp_flags,
    output rsp_tag,
    input  rsp_ready
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Issue sequencer and in-order result FIFO for a fixed-latency fpu.
// Define FPU_ISSUE_STATS_EN to add stat_issued/stat_stall counters.
module fpu_issue_ctrl #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  fpu_issue_ctrl_if.slave bus,
  output logic [2:0]  fpu_op,
  output logic [1:0]  fpu_rmode,
  output logic [31:0] fpu_opa,
  output logic [31:0] fpu_opb,
  input  logic [31:0] fpu_out,
  input  logic [7:0]  fpu_flags
`ifdef FPU_ISSUE_STATS_EN
  ,
  output logic [31:0] stat_issued,
  output logic [31:0] stat_stall
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+LATENCY+2)+1;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t state;

  logic [LATENCY:0] pv;
  logic [LATENCY:0] pi;
  logic [TAG_W-1:0] pt [LATENCY+1];

  logic [31:0]      mem_d [DEPTH];
  logic [8:0]       mem_f [DEPTH];
  logic [TAG_W-1:0] mem_t [DEPTH];

  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] cnt;
  logic [CW-1:0] inflight;

  logic accept;
  logic illegal;
  logic push;
  logic pop;
  logic drained;

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= LATENCY; i++)
      inflight = inflight + CW'(pv[i]);
  end

  // Credit: every op in flight already owns a FIFO slot.
  assign bus.req_ready = (state == RUN) & ~flush
                       & ((cnt + inflight) < CW'(DEPTH));

  assign accept  = bus.req_valid & bus.req_ready;
  assign illegal = bus.req_op[2];
  assign push    = pv[LATENCY] & (state == RUN);
  assign pop     = bus.rsp_valid & bus.rsp_ready;
  assign drained = (state == FLUSH) & (inflight == '0);

  assign bus.rsp_valid = (cnt != '0) & (state == RUN);
  assign bus.rsp_data  = mem_d[rp];
  assign bus.rsp_flags = mem_f[rp];
  assign bus.rsp_tag   = mem_t[rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      unique case (state)
        RUN:   if (flush) state <= FLUSH;
        FLUSH: if (inflight == '0) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !accept) begin
      fpu_op    <= '0;
      fpu_rmode <= '0;
      fpu_opa   <= '0;
      fpu_opb   <= '0;
    end else begin
      fpu_op    <= illegal ? 3'd0 : bus.req_op;
      fpu_rmode <= bus.req_rmode;
      fpu_opa   <= illegal ? 32'd0 : bus.req_opa;
      fpu_opb   <= illegal ? 32'd0 : bus.req_opb;
    end
  end

  // Stage 0 rides with the fpu_* registers; stage LATENCY
  // lines up with the cycle the fpu result is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      pi <= '0;
      for (int i = 0; i <= LATENCY; i++)
        pt[i] <= '0;
    end else begin
      pv    <= {pv[LATENCY-1:0], accept};
      pi    <= {pi[LATENCY-1:0], accept & illegal};
      pt[0] <= bus.req_tag;
      for (int i = 1; i <= LATENCY; i++)
        pt[i] <= pt[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] <= '0;
        mem_f[i] <= '0;
        mem_t[i] <= '0;
      end
    end else if (drained) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem_d[wp] <= pi[LATENCY] ? 32'h7fc00001 : fpu_out;
        mem_f[wp] <= pi[LATENCY] ? 9'h100
                                 : {1'b0, fpu_flags};
        mem_t[wp] <= pt[LATENCY];
        wp        <= wp + AW'(1);
      end
      if (pop)
        rp <= rp + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

`ifdef FPU_ISSUE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (accept && stat_issued != '1)
        stat_issued <= stat_issued + 32'd1;
      if (state == RUN && bus.req_valid &&
          !bus.req_ready && stat_stall != '1)
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl with a table-lookup fpu.
// Scoreboard queue filled on accept, drained on response.
module tb_fpu_issue_ctrl;
  localparam int LATENCY = 4;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  fpu_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

  logic [2:0]  fpu_op;
  logic [1:0]  fpu_rmode;
  logic [31:0] fpu_opa;
  logic [31:0] fpu_opb;
  logic [31:0] fpu_out;
  logic [7:0]  fpu_flags;
`ifdef FPU_ISSUE_STATS_EN
  logic [31:0] stat_issued;
  logic [31:0] stat_stall;
`endif

  fpu_issue_ctrl #(
    .LATENCY(LATENCY),
    .DEPTH(DEPTH),
    .TAG_W(TAG_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .bus(bus),
    .fpu_op(fpu_op),
    .fpu_rmode(fpu_rmode),
    .fpu_opa(fpu_opa),
    .fpu_opb(fpu_opb),
    .fpu_out(fpu_out),
    .fpu_flags(fpu_flags)
`ifdef FPU_ISSUE_STATS_EN
    ,
    .stat_issued(stat_issued),
    .stat_stall(stat_stall)
`endif
  );

  typedef struct {
    logic [2:0]       op;
    logic [1:0]       rm;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    logic [31:0]      d;
    logic [8:0]       f;
  } vec_t;

  typedef struct {
    logic [31:0]      d;
    logic [8:0]       f;
    logic [TAG_W-1:0] tag;
    int               acyc;
  } exp_t;

  vec_t vt [8];
  vec_t ill;
  exp_t sb [$];

  int tests = 0;
  int fails = 0;
  int cyc_no = 0;
  int acc_cnt = 0;
  int stall_cnt = 0;
  int pop_cnt = 0;
  bit chk_lat = 1'b0;

  function automatic logic [39:0] fpu_calc(
    logic [2:0] op, logic [31:0] a, logic [31:0] b);
    fpu_calc = {32'hdeadbeef, 8'h00};
    for (int i = 0; i < 8; i++)
      if (vt[i].op == op && vt[i].a == a && vt[i].b == b)
        fpu_calc = {vt[i].d, vt[i].f[7:0]};
  endfunction

  // fpu stand-in: LATENCY register stages after the sampling edge
  logic [39:0] fq [LATENCY];
  always @(posedge clk) begin
    fq[0] <= fpu_calc(fpu_op, fpu_opa, fpu_opb);
    for (int i = 1; i < LATENCY; i++)
      fq[i] <= fq[i-1];
  end
  assign {fpu_out, fpu_flags} = fq[LATENCY-1];

  task automatic check(string name,
                       logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic cyc();
    exp_t e;
    logic [39:0] r;
    #1;
    if (!rst) begin
      if (bus.req_valid && bus.req_ready) begin
        if (bus.req_op[2]) begin
          e.d = 32'h7fc00001;
          e.f = 9'h100;
        end else begin
          r = fpu_calc(bus.req_op, bus.req_opa, bus.req_opb);
          e.d = r[39:8];
          e.f = {1'b0, r[7:0]};
        end
        e.tag  = bus.req_tag;
        e.acyc = cyc_no;
        sb.push_back(e);
        acc_cnt++;
      end
      if (bus.req_valid && !bus.req_ready)
        stall_cnt++;
      if (bus.rsp_valid && bus.rsp_ready) begin
        pop_cnt++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: got tag %h data %h",
                   bus.rsp_tag, bus.rsp_data);
        end else begin
          e = sb.pop_front();
          check("rsp", {bus.rsp_data, bus.rsp_flags, bus.rsp_tag},
                {e.d, e.f, e.tag});
          // cyc_no-1 is the edge after which rsp_valid rose
          if (chk_lat)
            check("latency", 64'(cyc_no - 1 - e.acyc), LATENCY + 1);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc_no++;
  endtask

  task automatic set_req(vec_t v);
    bus.req_valid = 1'b1;
    bus.req_op    = v.op;
    bus.req_rmode = v.rm;
    bus.req_opa   = v.a;
    bus.req_opb   = v.b;
    bus.req_tag   = v.tag;
  endtask

  task automatic send(vec_t v);
    int a0;
    set_req(v);
    for (int g = 0; g < 50; g++) begin
      a0 = acc_cnt;
      cyc();
      if (acc_cnt != a0) return;
    end
    fail_now("send_accept");
  endtask

  task automatic drain();
    for (int g = 0; g < 60; g++) begin
      if (sb.size() == 0) return;
      cyc();
    end
    fail_now("drain");
  endtask

  task automatic idle(int n);
    bus.req_valid = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic check_zero(string pfx);
    check({pfx, "_fpu_op"}, fpu_op, 0);
    check({pfx, "_fpu_rmode"}, fpu_rmode, 0);
    check({pfx, "_fpu_ops"}, {fpu_opa, fpu_opb}, 0);
    check({pfx, "_rsp_valid"}, bus.rsp_valid, 0);
    check({pfx, "_rsp_fields"},
          {bus.rsp_data, bus.rsp_flags, bus.rsp_tag}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, p0, fcyc;
    bit seen;
    vt[0] = '{3'd0, 2'd0, 32'h3f800000, 32'h40000000, 4'd5,
              32'h40400000, 9'h000};
    vt[1] = '{3'd2, 2'd0, 32'h40000000, 32'h40400000, 4'd1,
              32'h40c00000, 9'h000};
    vt[2] = '{3'd3, 2'd0, 32'h3f800000, 32'h00000000, 4'd2,
              32'h7f800000, 9'h081};
    vt[3] = '{3'd1, 2'd1, 32'h40400000, 32'h3f800000, 4'd3,
              32'h40000000, 9'h000};
    vt[4] = '{3'd0, 2'd2, 32'h3f800000, 32'h3f800000, 4'd4,
              32'h40000000, 9'h000};
    vt[5] = '{3'd2, 2'd3, 32'h3f800000, 32'h3f800000, 4'd6,
              32'h3f800000, 9'h000};
    vt[6] = '{3'd3, 2'd0, 32'h40c00000, 32'h40000000, 4'd7,
              32'h40400000, 9'h000};
    vt[7] = '{3'd1, 2'd0, 32'h3f800000, 32'h3f800000, 4'd8,
              32'h00000000, 9'h040};
    ill   = '{3'd5, 2'd0, 32'h3f800000, 32'h40000000, 4'd3,
              32'h7fc00001, 9'h100};

    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_rmode = '0;
    bus.req_opa   = '0;
    bus.req_opb   = '0;
    bus.req_tag   = '0;
    bus.rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    check("reset_req_ready", bus.req_ready, 1);
    rst = 1'b0;
    idle(2);

    // Sequence 1: single add, latency measured
    chk_lat = 1'b1;
    send(vt[0]);
    idle(0);
    drain();
    chk_lat = 1'b0;
    idle(2);

    // Sequence 2: back-to-back table ops, in order
    p0 = pop_cnt;
    for (int i = 0; i < 8; i++) send(vt[i]);
    bus.req_valid = 1'b0;
    drain();
    check("b2b_count", pop_cnt - p0, 8);
    idle(2);

    // Sequence 3: backpressure, credit stops at DEPTH
    bus.rsp_ready = 1'b0;
    a0 = acc_cnt;
    for (int i = 0; i < 20; i++) begin
      set_req(vt[i % 8]);
      cyc();
    end
    check("bp_accepts", acc_cnt - a0, DEPTH);
    #1;
    check("bp_req_ready", bus.req_ready, 0);
    check("bp_rsp_valid", bus.rsp_valid, 1);
    check("bp_sb_size", sb.size(), DEPTH);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    p0 = pop_cnt;
    drain();
    check("bp_pops", pop_cnt - p0, DEPTH);
    a0 = acc_cnt;
    set_req(vt[6]);
    cyc();
    check("bp_resume", acc_cnt - a0, 1);
    bus.req_valid = 1'b0;
    drain();
    idle(2);

    // Sequence 4: illegal op keeps legal-op latency
    chk_lat = 1'b1;
    send(ill);
    bus.req_valid = 1'b0;
    drain();
    chk_lat = 1'b0;
    idle(2);

    // Sequence 5: flush with ops in pipe and FIFO
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(vt[i]);
    bus.req_valid = 1'b0;
    for (int g = 0; g < 20 && !bus.rsp_valid; g++) cyc();
    cyc();
    set_req(vt[4]);
    flush = 1'b1;
    #1;
    check("flush_req_ready", bus.req_ready, 0);
    cyc();
    flush = 1'b0;
    bus.req_valid = 1'b0;
    sb.delete();
    bus.rsp_ready = 1'b1;
    seen = 1'b0;
    fcyc = 0;
    for (int g = 0; g < 30; g++) begin
      #1;
      if (bus.req_ready) break;
      if (bus.rsp_valid) seen = 1'b1;
      fcyc++;
      cyc();
    end
    check("flush_rsp_hidden", seen, 0);
    check("flush_exit", bus.req_ready, 1);
    check("flush_had_drain", fcyc > 0, 1);
    check("flush_fifo_empty", bus.rsp_valid, 0);
    p0 = pop_cnt;
    send(vt[5]);
    bus.req_valid = 1'b0;
    drain();
    idle(8);
    check("flush_single_rsp", pop_cnt - p0, 1);

    // Sequence 6: reset mid-stream
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    acc_cnt = 0;
    stall_cnt = 0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(vt[i]);
    for (int i = 0; i < 3; i++) begin
      set_req(vt[4]);
      cyc();
    end
`ifdef FPU_ISSUE_STATS_EN
    check("stat_issued", stat_issued, acc_cnt);
    check("stat_stall", stat_stall, stall_cnt);
`endif
    rst = 1'b1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_zero("midrst");
`ifdef FPU_ISSUE_STATS_EN
    check("midrst_stats", {stat_issued, stat_stall}, 0);
`endif
    sb.delete();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    p0 = pop_cnt;
    idle(12);
    check("midrst_no_stale", pop_cnt - p0, 0);
    send(vt[7]);
    bus.req_valid = 1'b0;
    drain();
    idle(2);
    check("post_rst_rsp", pop_cnt - p0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
